// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for DIGITS common-anode 7-segment digits sharing one decoder.
// A double-buffered value is committed only at frame boundaries; every slot opens with a blank phase.
module seg7_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  lz_en,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   disp;
    logic [4*DIGITS-1:0]   shadow;

    logic                  slot_end;
    logic                  frame_end;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [IDX_W-1:0]      idx_nxt;
    logic [DIGITS-1:0]     blank_msk;
    logic [3:0]            nib_p0;
    logic [DIGITS-1:0]     an_p0;

    // Bit i set when digit i and every digit above it hold zero; digit 0 is never blanked.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (v[4*i +: 4] == 4'h0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
    assign idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    assign blank_msk = lz_en ? lz_mask(disp) : '0;

    always_comb begin
        nib_p0 = 4'h0;
        an_p0  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_p0 = disp[4*i +: 4];
                if (state == DRIVE && !blank_msk[i])
                    an_p0[i] = 1'b0;
            end
        end
    end

    // Output registers: everything seen at the pins lags the scan state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            bcd        <= 4'h0;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            state      <= (cnt_nxt < CNT_BLANK) ? BLANK : DRIVE;
            if (slot_end)
                idx <= idx_nxt;
            bcd        <= nib_p0;
            an         <= an_p0;
            frame_done <= frame_end;
            // A load landing on the boundary itself skips the shadow entirely.
            if (frame_end && load) begin
                disp    <= value;
                pending <= 1'b0;
            end else if (frame_end && pending) begin
                disp    <= shadow;
                pending <= 1'b0;
            end else if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    seg7_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .lz_en(lz_en),
        .bcd(bcd), .an(an), .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Output cycle label: 0 on a reset edge, 1 for outputs registered at the first free-running edge.
    int oc = 0;
    always @(posedge clk) begin
        if (rst) oc <= 0;
        else     oc <= oc + 1;
    end

    int nchk  = 0;
    int nfail = 0;

    typedef struct {
        logic [15:0] value;
        logic        lz;
        logic [15:0] exp_an;
    } vec_t;

    typedef struct {
        logic [3:0] bcd;
        logic [3:0] an;
    } slot_t;

    slot_t sb[$];
    vec_t  tab[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @oc=%0d: got %0h expected %0h", name, oc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mod(input int m);
        int n = 0;
        while ((oc % 32) != m && n < 100) begin
            step();
            n++;
        end
        if ((oc % 32) != m) begin
            nchk++;
            nfail++;
            $display("FAIL wait_mod timeout @oc=%0d: got %0d expected %0d", oc, oc % 32, m);
        end
    endtask

    task automatic push_exp(input logic [15:0] v, input logic [15:0] exp_an);
        slot_t s;
        for (int k = 0; k < 4; k++) begin
            s.bcd = v[4*k +: 4];
            s.an  = exp_an[4*k +: 4];
            sb.push_back(s);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic lz);
        value = v;
        lz_en = lz;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        slot_t s;
        for (int k = 0; k < 4; k++) begin
            wait_mod(k * 8 + 6);
            if (sb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL %s scoreboard empty: got 0 expected 1 entries", tag);
            end else begin
                s = sb.pop_front();
                chk({tag, "_bcd"}, {28'd0, bcd}, {28'd0, s.bcd});
                chk({tag, "_an"}, {28'd0, an}, {28'd0, s.an});
                chk({tag, "_pend"}, {31'd0, pending}, 32'd0);
            end
        end
    endtask

    // Continuous invariants on every output cycle outside reset.
    always begin
        @(posedge clk);
        #1;
        if (!rst && oc > 0) begin
            chk("an_onehot0", {31'd0, $onehot0(~an)}, 32'd1);
            if (((oc - 1) % 8) < 2)
                chk("an_blank_phase", {28'd0, an}, 32'hF);
            chk("frame_done_timing", {31'd0, frame_done}, {31'd0, (oc % 32) == 0});
        end
    end

    initial begin
        logic [15:0] prev;
        tab[0] = '{16'h4321, 1'b0, 16'h7BDE};
        tab[1] = '{16'h1111, 1'b0, 16'h7BDE};
        tab[2] = '{16'h2222, 1'b0, 16'h7BDE};
        tab[3] = '{16'h0040, 1'b1, 16'hFFDE};
        tab[4] = '{16'h0000, 1'b1, 16'hFFFE};
        tab[5] = '{16'h0000, 1'b0, 16'h7BDE};
        tab[6] = '{16'hFA0B, 1'b1, 16'h7BDE};
        tab[7] = '{16'h0100, 1'b1, 16'hFBDE};
        tab[8] = '{16'h0040, 1'b0, 16'h7BDE};

        rst = 1'b1;
        repeat (3) step();
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_bcd", {28'd0, bcd}, 32'h0);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        prev = 16'h0000;
        for (int i = 0; i < 9; i++) begin
            wait_mod(12);
            push_exp(tab[i].value, tab[i].exp_an);
            do_load(tab[i].value, tab[i].lz);
            chk("load_pending", {31'd0, pending}, 32'd1);
            wait_mod(22);
            chk("no_tear_bcd", {28'd0, bcd}, {28'd0, prev[11:8]});
            chk("no_tear_pending", {31'd0, pending}, 32'd1);
            wait_mod(0);
            chk("boundary_fd", {31'd0, frame_done}, 32'd1);
            chk("boundary_pending", {31'd0, pending}, 32'd0);
            check_frame("tab");
            prev = tab[i].value;
        end

        // Two loads in one frame: only the later survives.
        wait_mod(10);
        do_load(16'h5555, 1'b0);
        chk("lw_pending1", {31'd0, pending}, 32'd1);
        wait_mod(20);
        push_exp(16'h6666, 16'h7BDE);
        do_load(16'h6666, 1'b0);
        chk("lw_pending2", {31'd0, pending}, 32'd1);
        wait_mod(0);
        check_frame("last_wins");

        // Load in the boundary cycle goes straight to the display.
        wait_mod(31);
        chk("byp_pre_pending", {31'd0, pending}, 32'd0);
        push_exp(16'h7777, 16'h7BDE);
        do_load(16'h7777, 1'b0);
        chk("byp_pending", {31'd0, pending}, 32'd0);
        chk("byp_fd", {31'd0, frame_done}, 32'd1);
        check_frame("bypass");

        // Reset while a value is pending, during digit 2's slot.
        wait_mod(12);
        do_load(16'h9999, 1'b0);
        chk("mr_pending", {31'd0, pending}, 32'd1);
        wait_mod(19);
        rst = 1'b1;
        step();
        chk("mr_an", {28'd0, an}, 32'hF);
        chk("mr_bcd", {28'd0, bcd}, 32'h0);
        chk("mr_pending_clr", {31'd0, pending}, 32'd0);
        chk("mr_fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        push_exp(16'h0000, 16'h7BDE);
        check_frame("post_rst");
        push_exp(16'h0000, 16'h7BDE);
        check_frame("post_rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
